gf180mcu_fd_sc_mcu7t5v0_clkmon: RTL and testbench
=================================================

// Module: gf180mcu_fd_sc_mcu7t5v0_clkmon
// PURPOSE
//  - Receive end of the clock-distribution path: samples a buffered clock (I) as data in the CLK domain and checks its activity.
//  - Counts rising edges of I over a fixed window of CLK cycles and flags too-slow, too-fast or stuck clocks.
//  - Sits at clock-tree leaves or clock-mux outputs; flags feed a safety or status register.
// PARAMETERS
//  - SYNC_STAGES  2    synchronizer depth on I (>=2)
//  - WINDOW       100  measurement window length, CLK cycles (>=4)
//  - WIN_W        8    window counter width (2**WIN_W > WINDOW)
//  - CNT_W        8    edge counter / EDGES width
//  - MIN_EDGES    20   LO asserted when window edge count < MIN_EDGES
//  - MAX_EDGES    30   HI asserted when window edge count > MAX_EDGES
//  - STUCK_LIMIT  32   CLK cycles without an I edge before STUCK asserts
// PORTS
//  - CLK    in   1      reference clock; all flops rising-edge
//  - RN     in   1      asynchronous active-low reset
//  - EN     in   1      monitor enable, synchronous to CLK
//  - I      in   1      monitored clock, asynchronous to CLK
//  - EDGES  out  CNT_W  edge count of last completed window
//  - VALID  out  1      1-cycle pulse when EDGES/LO/HI update
//  - LO     out  1      last window count < MIN_EDGES
//  - HI     out  1      last window count > MAX_EDGES
//  - STUCK  out  1      no I edge for STUCK_LIMIT cycles
// BEHAVIOUR
//  - Reset (RN=0, async): all flops cleared; EDGES=0, VALID=0, LO=0, HI=0, STUCK=0, FSM=IDLE.
//  - I -> SYNC_STAGES flop chain -> i_s; edge = i_s & ~i_s_q (one registered delay).
//  - FSM: IDLE -(EN=1)-> ARM; ARM holds SYNC_STAGES+1 cycles (synchronizer refill, edges ignored) -> MEASURE.
//  - Any state -(EN=0)-> IDLE next cycle; window, edge and stuck counters cleared; EDGES/LO/HI hold; VALID=0.
//  - MEASURE: window counter 0..WINDOW-1; edge counter +1 per edge, saturating at 2**CNT_W-1.
//  - Terminal cycle (win==WINDOW-1): an edge in this cycle counts in the closing window; EDGES, LO, HI registered from final count; VALID=1 next cycle; counters restart at 0 (back-to-back windows, no gap).
//  - First VALID occurs SYNC_STAGES+1+WINDOW+1 cycles after EN rises.
//  - Stuck counter: runs in MEASURE only; cleared on each edge; saturates at STUCK_LIMIT; STUCK=1 the cycle after it reaches STUCK_LIMIT; STUCK clears the cycle after the next edge. Independent of window boundary.
//  - LO and HI are mutually exclusive by construction (MIN_EDGES <= MAX_EDGES required; elaboration-time check).
//  - EN low mid-window: partial count discarded, no VALID.
// CONFIGURATION
//  - CLKMON_GLITCH_FILTER_EN defined: 3-tap majority filter inserted after synchronizer; i_s is filtered value; +2 cycles latency; ARM lasts SYNC_STAGES+3 cycles; single-cycle I pulses rejected.
//  - Not defined: i_s taken directly from synchronizer; ARM lasts SYNC_STAGES+1.
// STRUCTURE
//  - Package gf180mcu_clkmon_pkg: FSM state enum (IDLE, ARM, MEASURE), default parameter constants, ARM length function.
//  - Sub-module gf180mcu_fd_sc_mcu7t5v0_clkmon_sync: SYNC_STAGES flop synchronizer with async active-low reset, optional filter under the macro.
//  - Top: FSM, window/edge/stuck counters, output registers.
// TESTING
//  - Reset: pulse RN low mid-MEASURE with I toggling -> all outputs 0 immediately, FSM IDLE, no VALID until EN path re-arms.
//  - In range: defaults, I period 4 CLK -> VALID every 100 cycles, EDGES=25, LO=0, HI=0, STUCK=0.
//  - Slow: I period 8 CLK -> EDGES in 12..13, LO=1, HI=0; fast: I period 2 CLK (macro off) -> EDGES=50, HI=1.
//  - Stuck: stop I low after last edge -> STUCK=1 exactly 33 cycles after that edge's detect; restart I -> STUCK=0 one cycle after first detected edge.
//  - EN drop: deassert EN at window cycle 50 -> no VALID, EDGES/LO/HI hold; re-assert -> first VALID after SYNC_STAGES+2+WINDOW cycles.
//  - Macro: with CLKMON_GLITCH_FILTER_EN, inject 1-cycle I glitches on a static I -> EDGES=0 and STUCK asserts; without macro same stimulus counts glitches.

Source files
------------

// File: rtl/gf180mcu_clkmon_pkg.sv
// Shared definitions for the clock activity monitor.
//  - state_t   : monitor FSM states (IDLE, ARM, MEASURE)
//  - DEF_*     : default parameter values used by the top level
//  - arm_len() : number of ARM cycles. This is the time needed to refill the
//                input pipeline after enable.
//  - maj3()    : 3-input majority, used by the optional glitch filter
// Optional feature macro: CLKMON_GLITCH_FILTER_EN. It adds two cycles of
// input latency, so ARM is two cycles longer when the macro is defined.
package gf180mcu_clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WINDOW      = 100;
  localparam int DEF_WIN_W       = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MIN_EDGES   = 20;
  localparam int DEF_MAX_EDGES   = 30;
  localparam int DEF_STUCK_LIMIT = 32;

  // The edge detector needs the whole input pipeline refilled with post-enable
  // samples, plus the one registered delay of the edge detector itself.
  function automatic int arm_len(input int sync_stages);
`ifdef CLKMON_GLITCH_FILTER_EN
    return sync_stages + 3;
`else
    return sync_stages + 1;
`endif
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_clkmon_sync.sv
// Brings the monitored clock into the reference clock domain as plain data.
//  clk : reference clock
//  rn  : asynchronous active-low reset, clears every flop
//  d   : asynchronous input (monitored clock)
//  q   : synchronized value (filtered when the macro is defined)
// Optional feature macro: CLKMON_GLITCH_FILTER_EN. When it is defined, a
// 3-tap majority filter with a registered output follows the synchronizer.
// This adds 2 cycles of latency and removes single-cycle pulses.
module gf180mcu_fd_sc_mcu7t5v0_clkmon_sync
  import gf180mcu_clkmon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

`ifdef CLKMON_GLITCH_FILTER_EN
  // The filter taps hold the two previous synchronizer outputs. A level must
  // be present in 2 of 3 consecutive samples before it reaches q.
  logic [1:0] tap;
  logic       maj_q;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      tap   <= '0;
      maj_q <= 1'b0;
    end else begin
      tap   <= {tap[0], chain[SYNC_STAGES-1]};
      maj_q <= maj3(chain[SYNC_STAGES-1], tap[0], tap[1]);
    end
  end

  assign q = maj_q;
`else
  assign q = chain[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_clkmon.sv
// Clock activity monitor. It counts rising edges of the monitored clock I
// over a fixed window of CLK cycles and reports slow, fast and stuck clocks.
//  CLK       : reference clock, all flops rising-edge
//  RN        : asynchronous active-low reset
//  EN        : monitor enable (CLK domain)
//  I         : monitored clock (asynchronous)
//  EDGES     : edge count of the last completed window
//  VALID     : 1-cycle pulse when EDGES/LO/HI update
//  LO / HI   : last window count below MIN_EDGES / above MAX_EDGES
//  STUCK     : no edge of I seen for STUCK_LIMIT measuring cycles
//  DBG_STATE : current FSM state, for observation only
// Optional feature macro: CLKMON_GLITCH_FILTER_EN. It enables the input
// glitch filter inside the synchronizer and lengthens ARM to match.
module gf180mcu_fd_sc_mcu7t5v0_clkmon
  import gf180mcu_clkmon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_EDGES   = DEF_MIN_EDGES,
  parameter int MAX_EDGES   = DEF_MAX_EDGES,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             I,
  output logic [CNT_W-1:0] EDGES,
  output logic             VALID,
  output logic             LO,
  output logic             HI,
  output logic             STUCK,
  output state_t           DBG_STATE
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2)         begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
  if (WINDOW < 4)              begin : g_bad_win  $error("WINDOW must be >= 4"); end
  if ((1 << WIN_W) <= WINDOW)  begin : g_bad_winw $error("WIN_W too small for WINDOW"); end
  if (MIN_EDGES > MAX_EDGES)   begin : g_bad_lim  $error("MIN_EDGES must be <= MAX_EDGES"); end

  localparam int ARM_LEN = arm_len(SYNC_STAGES);
  localparam int ARM_W   = $clog2(ARM_LEN + 1);
  localparam int STK_W   = $clog2(STUCK_LIMIT + 1);

  localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_EDGES);

  logic i_s;
  logic i_s_q;
  logic edge_det;

  gf180mcu_fd_sc_mcu7t5v0_clkmon_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rn (RN),
    .d  (I),
    .q  (i_s)
  );

  // The edge detector runs all the time. Its history is then already valid
  // when ARM ends, and ARM simply ignores the edges it reports.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) i_s_q <= 1'b0;
    else     i_s_q <= i_s;
  end

  assign edge_det = i_s & ~i_s_q;

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] stk;
  logic [CNT_W-1:0] cnt_inc;

  // Edge count including this cycle's edge. It saturates at the maximum
  // value instead of wrapping.
  always_comb begin
    cnt_inc = cnt;
    if (edge_det && (cnt != CNT_MAX)) cnt_inc = cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      arm_cnt <= '0;
      win     <= '0;
      cnt     <= '0;
      stk     <= '0;
      EDGES   <= '0;
      VALID   <= 1'b0;
      LO      <= 1'b0;
      HI      <= 1'b0;
      STUCK   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (!EN) begin
        // Disable discards the partial window. Published results are held.
        state   <= IDLE;
        arm_cnt <= '0;
        win     <= '0;
        cnt     <= '0;
        stk     <= '0;
        STUCK   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            arm_cnt <= '0;
            STUCK   <= 1'b0;
          end
          ARM: begin
            STUCK <= 1'b0;
            if (arm_cnt == ARM_LAST) begin
              state <= MEASURE;
              win   <= '0;
              cnt   <= '0;
              stk   <= '0;
            end else begin
              arm_cnt <= arm_cnt + ARM_W'(1);
            end
          end
          MEASURE: begin
            if (win == WIN_LAST) begin
              // An edge in the terminal cycle still belongs to the closing
              // window. The next window starts with no gap.
              win   <= '0;
              cnt   <= '0;
              EDGES <= cnt_inc;
              LO    <= (cnt_inc < MIN_C);
              HI    <= (cnt_inc > MAX_C);
              VALID <= 1'b1;
            end else begin
              win <= win + WIN_W'(1);
              cnt <= cnt_inc;
            end
            // The stuck timer ignores window boundaries. STUCK follows the
            // timer one cycle after it saturates.
            if (edge_det)              stk <= '0;
            else if (stk != STK_LIMIT) stk <= stk + STK_W'(1);
            STUCK <= ~edge_det & (stk == STK_LIMIT);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0_clkmon.sv
// Self-checking bench for the clock activity monitor (default parameters).
// A cycle-level model derives the expected outputs from the enable run length,
// the sampled history of I, and the window/stuck rules.
// Directed checks with literal values pin the model.
module tb_gf180mcu_fd_sc_mcu7t5v0_clkmon;
  import gf180mcu_clkmon_pkg::*;

  localparam int S      = 2;
  localparam int WINDOW = 100;
  localparam int LIMIT  = 32;
  localparam int MINE   = 20;
  localparam int MAXE   = 30;
  localparam int CNT_W  = 8;
`ifdef CLKMON_GLITCH_FILTER_EN
  localparam bit FILT    = 1'b1;
  localparam int FLAT    = 2;
`else
  localparam bit FILT    = 1'b0;
  localparam int FLAT    = 0;
`endif
  localparam int ARM_LEN = S + 1 + FLAT;
  localparam int HL      = S + 5;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rn   = 1'b0;
  logic en   = 1'b0;
  logic i_in = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] edges;
  logic             valid, lo, hi, stuck;
  state_t           dbg_state;

  gf180mcu_fd_sc_mcu7t5v0_clkmon dut (
    .CLK      (clk),
    .RN       (rn),
    .EN       (en),
    .I        (i_in),
    .EDGES    (edges),
    .VALID    (valid),
    .LO       (lo),
    .HI       (hi),
    .STUCK    (stuck),
    .DBG_STATE(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- I waveform driver ----------------
  // Configuration is changed just after a posedge. The generator applies it
  // at the following negedge.
  int   i_period     = 0;
  int   glitch_every = 0;
  int   phase        = 0;
  logic i_static     = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (i_period > 0) begin
        phase = (phase + 1) % i_period;
        i_in  = (phase < i_period / 2);
      end else if (glitch_every > 0) begin
        phase = (phase + 1) % glitch_every;
        i_in  = (phase == 0);
      end else begin
        i_in = i_static;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic             hist[$];   // hist[0] = I sampled at the current posedge
  int               run;       // consecutive posedges with EN high
  int               wcnt;      // edges in the open window
  int               gap;       // measuring cycles since last edge
  logic             m_valid, m_lo, m_hi, m_stuck;
  logic [CNT_W-1:0] m_edges;
  state_t           m_state;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  // Level seen by the edge detector, d cycles older than the newest one.
  function automatic logic seen(input int d);
    if (FILT) return maj(hist[S+1+d], hist[S+2+d], hist[S+3+d]);
    return hist[S+d];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < HL; k++) hist.push_back(1'b0);
    run = 0; wcnt = 0; gap = 0;
    m_valid = 0; m_lo = 0; m_hi = 0; m_stuck = 0; m_edges = '0;
    m_state = IDLE;
  endtask

  task automatic model_step();
    logic ed;
    int   p;
    hist.push_front(i_in);
    void'(hist.pop_back());
    ed = seen(0) & ~seen(1);
    m_valid = 0;
    if (!en) begin
      run = 0; wcnt = 0; gap = 0; m_stuck = 0;
    end else begin
      run++;
      if (run >= ARM_LEN + 2) begin
        p = run - (ARM_LEN + 2);
        if (ed && wcnt < 255) wcnt++;
        if (p % WINDOW == WINDOW - 1) begin
          m_edges = CNT_W'(wcnt);
          m_lo    = (wcnt < MINE);
          m_hi    = (wcnt > MAXE);
          m_valid = 1;
          wcnt    = 0;
        end
        gap     = ed ? 0 : gap + 1;
        m_stuck = (gap > LIMIT);
      end else begin
        m_stuck = 0;
        gap     = 0;
      end
    end
    m_state = (run == 0) ? IDLE : (run <= ARM_LEN) ? ARM : MEASURE;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rn);
      if (!rn) model_reset();
      else     model_step();
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (rn) begin
      check("cyc_valid", valid, m_valid);
      check("cyc_edges", edges, m_edges);
      check("cyc_lo", lo, m_lo);
      check("cyc_hi", hi, m_hi);
      check("cyc_stuck", stuck, m_stuck);
      check("cyc_state", dbg_state, m_state);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (valid) return;
    end
    check({name, "_timeout"}, 0, 1);
    n = -1;
  endtask

  task automatic cfg_wave(input int per, input int glitch, input logic lvl);
    @(posedge clk);
    #1;
    i_period = per; glitch_every = glitch; i_static = lvl;
  endtask

  // ---------------- directed test sequence ----------------
  int n;
  int c;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_edges", edges, 0);
    check("rst_valid", valid, 0);
    check("rst_lo", lo, 0);
    check("rst_hi", hi, 0);
    check("rst_stuck", stuck, 0);
    check("rst_state", dbg_state, IDLE);
    #2 rn = 1'b1;

    // In range: period 4 -> 25 edges per window
    cfg_wave(4, 0, 1'b0);
    @(negedge clk);
    en = 1'b1;
    wait_valid("first", n);
    check("first_valid_latency", n, 104);
    wait_valid("inrange", n);
    check("inrange_period", n, 100);
    check("inrange_edges", edges, 25);
    check("inrange_lo", lo, 0);
    check("inrange_hi", hi, 0);
    check("inrange_stuck", stuck, 0);

    // Slow: period 8
    cfg_wave(8, 0, 1'b0);
    wait_valid("slow_a", n);
    wait_valid("slow_b", n);
    check("slow_edges_range", (edges >= 12 && edges <= 13), 1);
    check("slow_lo", lo, 1);
    check("slow_hi", hi, 0);

    // Fast: period 2
    cfg_wave(2, 0, 1'b0);
    wait_valid("fast_a", n);
    wait_valid("fast_b", n);
    check("fast_edges", edges, 50);
    check("fast_hi", hi, 1);
    check("fast_lo", lo, 0);

    // Stuck: single rise, then I held high
    cfg_wave(0, 0, 1'b0);
    repeat (4) @(posedge clk);
    cfg_wave(0, 0, 1'b1);
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (stuck) break;
    end
    check("stuck_rise_cycles", c, 37 + FLAT);
    // Restart: low for a few cycles, then one rise
    cfg_wave(0, 0, 1'b0);
    repeat (4) @(posedge clk);
    check("stuck_held_while_low", stuck, 1);
    cfg_wave(0, 0, 1'b1);
    c = 0;
    while (c < 50) begin
      @(negedge clk);
      c++;
      if (!stuck) break;
    end
    check("stuck_clear_cycles", c, 4 + FLAT);

    // EN drop mid-window
    cfg_wave(4, 0, 1'b0);
    wait_valid("endrop_a", n);
    wait_valid("endrop_b", n);
    check("endrop_pre_edges", edges, 25);
    repeat (50) @(negedge clk);
    en = 1'b0;
    c = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid) c++;
    end
    check("endrop_no_valid", c, 0);
    check("endrop_hold_edges", edges, 25);
    check("endrop_hold_lo", lo, 0);
    check("endrop_state", dbg_state, IDLE);
    en = 1'b1;
    wait_valid("endrop_re", n);
    check("endrop_rearm_latency", n, 104);
    check("endrop_re_edges", edges, 25);

    // Asynchronous reset mid-measure with I toggling
    repeat (30) @(negedge clk);
    #2 rn = 1'b0;
    #1;
    check("arst_edges", edges, 0);
    check("arst_valid", valid, 0);
    check("arst_lo", lo, 0);
    check("arst_hi", hi, 0);
    check("arst_stuck", stuck, 0);
    check("arst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    #2 rn = 1'b1;
    wait_valid("arst_re", n);
    check("arst_rearm_latency", n, 104);

    // Single-cycle glitches on a static-low I, one every 10 cycles
    cfg_wave(0, 10, 1'b0);
    wait_valid("glitch_a", n);
    wait_valid("glitch_b", n);
`ifdef CLKMON_GLITCH_FILTER_EN
    check("glitch_edges", edges, 0);
    check("glitch_lo", lo, 1);
    check("glitch_stuck", stuck, 1);
`else
    check("glitch_edges", edges, 10);
    check("glitch_lo", lo, 1);
    check("glitch_stuck", stuck, 0);
`endif

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
